// File: rtl/fetch_pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_pkg
// Shared fetch-stage types: the default PC width, the fetch packet handed from
// fetch to decode, and the occupancy states of the fetch skid buffer.
// -----------------------------------------------------------------------------
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

package fetch_pc_unit_pkg;

   localparam int unsigned PC_SIZE = `PC_SIZE;

   // One fetched PC together with the prediction made for it.
   typedef struct packed {
      logic [PC_SIZE-1:0] pc;
      logic               pred_taken;
      logic [PC_SIZE-1:0] pred_next;
   } fetch_pkt_t;

   // Skid buffer occupancy; the encoding equals the entry count.
   typedef enum logic [1:0] {
      SKID_EMPTY   = 2'd0,
      SKID_PARTIAL = 2'd1,
      SKID_FULL    = 2'd2
   } skid_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// Generic 2-entry valid/ready FIFO with a flush input.
//
// Handshake: a transfer happens on a side in any cycle where its valid and
// ready are both high; valid never waits for ready, data is stable while
// valid is high and ready is low.
//
// Ports:
//   clk, n_rst    clock, asynchronous active-low reset
//   flush_i       drop all entries; no enqueue that cycle
//   in_valid_i    producer offers in_data_i
//   in_ready_o    room available (not full, or head leaving this cycle)
//   in_data_i     payload to enqueue
//   out_valid_o   head entry present (registered state only)
//   out_ready_i   consumer takes the head
//   out_data_o    head payload; all zeros while empty
//   state_o       occupancy state (EMPTY / PARTIAL / FULL)
// -----------------------------------------------------------------------------
module fetch_skid_buffer
   import fetch_pc_unit_pkg::*;
#(
   parameter type T_DATA = logic
)(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        flush_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  T_DATA       in_data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output T_DATA       out_data_o,
   output skid_state_e state_o
);

   skid_state_e state_q, state_d;
   T_DATA       head_q, head_d;
   T_DATA       tail_q, tail_d;
   logic        push;
   logic        pop;

   assign out_valid_o = (state_q != SKID_EMPTY);
   assign pop         = out_valid_o & out_ready_i;
   assign in_ready_o  = (state_q != SKID_FULL) | pop;
   assign push        = in_valid_i & in_ready_o & ~flush_i;

   // The head register is zeroed whenever the buffer goes empty, so the data
   // output is a plain register with no empty-mux in front of it.
   assign out_data_o  = head_q;
   assign state_o     = state_q;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush_i) begin
         state_d = SKID_EMPTY;
         head_d  = '0;
         tail_d  = '0;
      end else begin
         case (state_q)
            SKID_EMPTY: begin
               if (push) begin
                  head_d  = in_data_i;
                  state_d = SKID_PARTIAL;
               end
            end
            SKID_PARTIAL: begin
               case ({push, pop})
                  2'b10: begin
                     tail_d  = in_data_i;
                     state_d = SKID_FULL;
                  end
                  // Head leaves while a new entry arrives: it becomes the head.
                  2'b11: head_d = in_data_i;
                  2'b01: begin
                     head_d  = '0;
                     state_d = SKID_EMPTY;
                  end
                  default: ;
               endcase
            end
            SKID_FULL: begin
               // A push while full is only possible together with a pop.
               if (pop) begin
                  head_d = tail_q;
                  if (push) begin
                     tail_d = in_data_i;
                  end else begin
                     tail_d  = '0;
                     state_d = SKID_PARTIAL;
                  end
               end
            end
            default: begin
               state_d = SKID_EMPTY;
               head_d  = '0;
               tail_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= SKID_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Fetch-stage next-PC generator. Holds the fetch PC, presents it to the BTB,
// forms the predicted next PC from the BTB answer and queues each fetched PC
// with its prediction into a 2-entry skid buffer toward decode. A redirect
// from branch resolution overrides prediction and flushes the buffer.
//
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   btb_pc            lookup PC to the BTB (the fetch PC register)
//   btb_hit/branch    BTB tag match / entry is a taken branch
//   btb_target        BTB predicted target
//   redirect_valid    resolution stage forces a PC change (highest priority)
//   redirect_pc       corrected PC
//   out_valid/ready   head of skid buffer toward decode (valid/ready)
//   out_pc            PC of the head entry
//   out_pred_taken    prediction recorded for the head
//   out_pred_target   predicted next PC recorded for the head
//   dbg_state         skid buffer occupancy state
// -----------------------------------------------------------------------------
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned     PC_W     = `PC_SIZE,
   parameter logic [PC_W-1:0] RESET_PC = '0
)(
   input  logic            clk,
   input  logic            n_rst,
   output logic [PC_W-1:0] btb_pc,
   input  logic            btb_hit,
   input  logic            btb_branch,
   input  logic [PC_W-1:0] btb_target,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic            out_pred_taken,
   output logic [PC_W-1:0] out_pred_target,
   output skid_state_e     dbg_state
);

   // Same layout as fetch_pkt_t, sized by this instance's PC width.
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            pred_taken;
      logic [PC_W-1:0] pred_next;
   } pkt_t;

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   logic [PC_W-1:0] pc_q, pc_d;
   logic            pred_taken;
   logic [PC_W-1:0] pred_next;
   logic            fifo_in_ready;
   logic            push;
   pkt_t            in_pkt;
   pkt_t            head_pkt;

   assign btb_pc     = pc_q;
   assign pred_taken = btb_hit & btb_branch;
   // Sequential increment wraps naturally at the PC width.
   assign pred_next  = pred_taken ? btb_target : (pc_q + PC_ONE);
   assign push       = ~redirect_valid & fifo_in_ready;

   assign in_pkt.pc         = pc_q;
   assign in_pkt.pred_taken = pred_taken;
   assign in_pkt.pred_next  = pred_next;

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (push) begin
         pc_d = pred_next;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // A redirect both blocks the push and flushes; a head popped in the same
   // cycle is still handshaken and decode is expected to drop it.
   fetch_skid_buffer #(
      .T_DATA (pkt_t)
   ) u_skid (
      .clk         (clk),
      .n_rst       (n_rst),
      .flush_i     (redirect_valid),
      .in_valid_i  (~redirect_valid),
      .in_ready_o  (fifo_in_ready),
      .in_data_i   (in_pkt),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (head_pkt),
      .state_o     (dbg_state)
   );

   assign out_pc          = head_pkt.pc;
   assign out_pred_taken  = head_pkt.pred_taken;
   assign out_pred_target = head_pkt.pred_next;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
   import fetch_pc_unit_pkg::*;

   localparam int unsigned     W        = PC_SIZE;
   localparam logic [W-1:0]    RST_PC   = W'(32'h10);

   logic          clk;
   logic          n_rst;
   logic [W-1:0]  btb_pc;
   logic          btb_hit;
   logic          btb_branch;
   logic [W-1:0]  btb_target;
   logic          redirect_valid;
   logic [W-1:0]  redirect_pc;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_pc;
   logic          out_pred_taken;
   logic [W-1:0]  out_pred_target;
   skid_state_e   dbg_state;

   // Tiny BTB model: one entry that reports a taken branch.
   logic          bt_en;
   logic [W-1:0]  bt_pc;
   logic [W-1:0]  bt_tgt;

   int pass_cnt = 0;
   int total    = 0;

   fetch_pc_unit #(.PC_W(W), .RESET_PC(RST_PC)) dut (
      .clk             (clk),
      .n_rst           (n_rst),
      .btb_pc          (btb_pc),
      .btb_hit         (btb_hit),
      .btb_branch      (btb_branch),
      .btb_target      (btb_target),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_pred_taken  (out_pred_taken),
      .out_pred_target (out_pred_target),
      .dbg_state       (dbg_state)
   );

   assign btb_hit    = bt_en && (btb_pc == bt_pc);
   assign btb_branch = btb_hit;
   assign btb_target = btb_hit ? bt_tgt : '0;

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      bt_en = 1'b1; bt_pc = W'(32'h12); bt_tgt = W'(32'h40);
      #12;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", out_valid); else pass_cnt++;
      total++; if (out_pc !== '0) $display("FAIL rst_out_pc got %0h exp 0", out_pc); else pass_cnt++;
      total++; if (out_pred_taken !== 1'b0) $display("FAIL rst_taken got %0b exp 0", out_pred_taken); else pass_cnt++;
      total++; if (out_pred_target !== '0) $display("FAIL rst_target got %0h exp 0", out_pred_target); else pass_cnt++;
      total++; if (btb_pc !== RST_PC) $display("FAIL rst_btb_pc got %0h exp %0h", btb_pc, RST_PC); else pass_cnt++;
      n_rst = 1'b1;
   endtask

   task automatic test_sequential();
      logic [W-1:0] exp_pc;
      for (int i = 0; i < 2; i++) begin
         tick();
         exp_pc = RST_PC + W'(i);
         total++; if (out_valid !== 1'b1) $display("FAIL seq_valid[%0d] got %0b exp 1", i, out_valid); else pass_cnt++;
         total++; if (out_pc !== exp_pc) $display("FAIL seq_pc[%0d] got %0h exp %0h", i, out_pc, exp_pc); else pass_cnt++;
         total++; if (out_pred_taken !== 1'b0) $display("FAIL seq_taken[%0d] got %0b exp 0", i, out_pred_taken); else pass_cnt++;
         total++; if (out_pred_target !== exp_pc + W'(1)) $display("FAIL seq_target[%0d] got %0h exp %0h", i, out_pred_target, exp_pc + W'(1)); else pass_cnt++;
      end
   endtask

   task automatic test_branch();
      tick();
      total++; if (out_pc !== W'(32'h12)) $display("FAIL br_pc got %0h exp 12", out_pc); else pass_cnt++;
      total++; if (out_pred_taken !== 1'b1) $display("FAIL br_taken got %0b exp 1", out_pred_taken); else pass_cnt++;
      total++; if (out_pred_target !== W'(32'h40)) $display("FAIL br_target got %0h exp 40", out_pred_target); else pass_cnt++;
      total++; if (btb_pc !== W'(32'h40)) $display("FAIL br_btb_pc got %0h exp 40", btb_pc); else pass_cnt++;
      tick();
      total++; if (out_pc !== W'(32'h40)) $display("FAIL br_next_pc got %0h exp 40", out_pc); else pass_cnt++;
      total++; if (out_pred_taken !== 1'b0) $display("FAIL br_next_taken got %0b exp 0", out_pred_taken); else pass_cnt++;
   endtask

   task automatic test_stall();
      logic [W-1:0] exp_pc;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (out_pc !== W'(32'h40)) $display("FAIL stall_pc[%0d] got %0h exp 40", i, out_pc); else pass_cnt++;
         total++; if (dbg_state !== SKID_FULL) $display("FAIL stall_state[%0d] got %0d exp 2", i, dbg_state); else pass_cnt++;
         total++; if (btb_pc !== W'(32'h42)) $display("FAIL stall_btb_pc[%0d] got %0h exp 42", i, btb_pc); else pass_cnt++;
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_pc = W'(32'h41) + W'(i);
         total++; if (out_pc !== exp_pc) $display("FAIL drain_pc[%0d] got %0h exp %0h", i, out_pc, exp_pc); else pass_cnt++;
         total++; if (btb_pc !== exp_pc + W'(2)) $display("FAIL drain_btb_pc[%0d] got %0h exp %0h", i, btb_pc, exp_pc + W'(2)); else pass_cnt++;
      end
      total++; if (dbg_state !== SKID_FULL) $display("FAIL drain_state got %0d exp 2", dbg_state); else pass_cnt++;
   endtask

   task automatic test_redirect();
      redirect_valid = 1'b1; redirect_pc = W'(32'h80);
      tick();
      redirect_valid = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL redir_valid got %0b exp 0", out_valid); else pass_cnt++;
      total++; if (btb_pc !== W'(32'h80)) $display("FAIL redir_btb_pc got %0h exp 80", btb_pc); else pass_cnt++;
      total++; if (dbg_state !== SKID_EMPTY) $display("FAIL redir_state got %0d exp 0", dbg_state); else pass_cnt++;
      total++; if (out_pc !== '0) $display("FAIL redir_empty_pc got %0h exp 0", out_pc); else pass_cnt++;
      tick();
      total++; if (out_valid !== 1'b1) $display("FAIL redir_out_valid got %0b exp 1", out_valid); else pass_cnt++;
      total++; if (out_pc !== W'(32'h80)) $display("FAIL redir_out_pc got %0h exp 80", out_pc); else pass_cnt++;
      total++; if (out_pred_target !== W'(32'h81)) $display("FAIL redir_target got %0h exp 81", out_pred_target); else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [W-1:0] max_pc;
      max_pc = '1;
      redirect_valid = 1'b1; redirect_pc = max_pc;
      tick();
      redirect_valid = 1'b0;
      tick();
      total++; if (out_pc !== max_pc) $display("FAIL wrap_pc got %0h exp %0h", out_pc, max_pc); else pass_cnt++;
      total++; if (out_pred_target !== '0) $display("FAIL wrap_target got %0h exp 0", out_pred_target); else pass_cnt++;
      total++; if (btb_pc !== '0) $display("FAIL wrap_btb_pc got %0h exp 0", btb_pc); else pass_cnt++;
      tick();
      total++; if (out_pc !== '0) $display("FAIL wrap_next_pc got %0h exp 0", out_pc); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      tick();
      #3;
      n_rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL arst_valid got %0b exp 0", out_valid); else pass_cnt++;
      total++; if (out_pc !== '0) $display("FAIL arst_pc got %0h exp 0", out_pc); else pass_cnt++;
      total++; if (btb_pc !== RST_PC) $display("FAIL arst_btb_pc got %0h exp %0h", btb_pc, RST_PC); else pass_cnt++;
      total++; if (dbg_state !== SKID_EMPTY) $display("FAIL arst_state got %0d exp 0", dbg_state); else pass_cnt++;
      #2;
      n_rst = 1'b1;
      tick();
      total++; if (out_pc !== RST_PC) $display("FAIL arst_restart_pc got %0h exp %0h", out_pc, RST_PC); else pass_cnt++;
      total++; if (btb_pc !== RST_PC + W'(1)) $display("FAIL arst_restart_btb got %0h exp %0h", btb_pc, RST_PC + W'(1)); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_stall();
      test_redirect();
      test_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
